// File: rtl/alu_issue_wb.sv
// rtl/alu_issue_wb.sv - operand-fetch / write-back stage around an external 8-bit ALU
module alu_issue_wb #(
    parameter int NUM_REGS = 4,
    parameter int REG_AW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_use_imm,
    input  logic [7:0]        in_imm,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [4:0]        alu_opcode,
    input  logic [7:0]        alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_parity,
    input  logic              alu_overflow,
    input  logic              alu_borrow,
    output logic              done,
    output logic [7:0]        wb_data,
    output logic [4:0]        flags,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_SUB = 5'h01;
    localparam logic [4:0] OP_LDI = 5'h10;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t            state;
    logic [7:0]        regs [NUM_REGS];
    logic [REG_AW-1:0] rd_q;
    logic              carry_ok;

    assign in_ready = (state == IDLE);
    assign dbg_data = regs[dbg_addr];

    // The ALU leaves carry undefined outside ADD/SUB, so it must be masked.
    assign carry_ok = (alu_opcode == OP_ADD) || (alu_opcode == OP_SUB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
            rd_q       <= '0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_opcode <= 5'h1F;
            done       <= 1'b0;
            wb_data    <= 8'h00;
            flags      <= 5'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_op == OP_LDI) begin
                            regs[in_rd] <= in_imm;
                            wb_data     <= in_imm;
                            done        <= 1'b1;
                        end else begin
                            alu_a      <= regs[in_rs1];
                            alu_b      <= in_use_imm ? in_imm : regs[in_rs2];
                            alu_opcode <= in_op;
                            rd_q       <= in_rd;
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    regs[rd_q] <= alu_result;
                    wb_data    <= alu_result;
                    done       <= 1'b1;
                    flags      <= {alu_borrow, alu_overflow, alu_parity, alu_zero,
                                   alu_carry & carry_ok};
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb/tb_alu_issue_wb.sv - self-checking bench for alu_issue_wb with a behavioural ALU
module tb_alu_issue_wb;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_op;
    logic [1:0] in_rd, in_rs1, in_rs2;
    logic       in_use_imm;
    logic [7:0] in_imm;
    logic [7:0] alu_a, alu_b;
    logic [4:0] alu_opcode;
    logic [7:0] alu_result;
    logic       alu_carry, alu_zero, alu_parity, alu_overflow, alu_borrow;
    logic       done;
    logic [7:0] wb_data;
    logic [4:0] flags;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_regs [4];
    logic [4:0] m_flags;

    always #5 clk = ~clk;

    alu_issue_wb #(.NUM_REGS(4), .REG_AW(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_imm(in_use_imm), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_parity(alu_parity), .alu_overflow(alu_overflow), .alu_borrow(alu_borrow),
        .done(done), .wb_data(wb_data), .flags(flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Returns {borrow, overflow, parity, zero, raw_carry, result[7:0]}; raw carry is 1 outside ADD/SUB.
    function automatic logic [12:0] alu_fn(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] res;
        logic c, ov, bo;
        c = 1'b1; ov = 1'b0; bo = 1'b0;
        case (op)
            5'h00: begin
                s = {1'b0, a} + {1'b0, b}; res = s[7:0]; c = s[8];
                ov = (a[7] == b[7]) && (res[7] != a[7]);
            end
            5'h01: begin
                res = a - b; c = (a < b); bo = (a < b);
                ov = (a[7] != b[7]) && (res[7] != a[7]);
            end
            5'h02: res = a & b;
            5'h03: res = a | b;
            5'h04: res = a ^ b;
            5'h05: res = ~a;
            5'h06: res = a << 1;
            5'h07: res = a >> 1;
            5'h08: res = a + 8'd1;
            5'h09: res = a - 8'd1;
            default: res = (op < 5'h10) ? b : 8'h00;
        endcase
        return {bo, ov, ^res, (res == 8'h00), c, res};
    endfunction

    logic [12:0] alu_r;
    assign alu_r        = alu_fn(alu_opcode, alu_a, alu_b);
    assign alu_result   = alu_r[7:0];
    assign alu_carry    = alu_r[8];
    assign alu_zero     = alu_r[9];
    assign alu_parity   = alu_r[10];
    assign alu_overflow = alu_r[11];
    assign alu_borrow   = alu_r[12];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [4:0] op, input logic [1:0] rd, input logic [7:0] a, input logic [7:0] b);
        logic [12:0] r;
        r = alu_fn(op, a, b);
        m_regs[rd] = r[7:0];
        m_flags = {r[12:9], r[8] & (op == 5'h00 || op == 5'h01)};
    endtask

    task automatic check_reg(input logic [1:0] idx);
        dbg_addr = idx;
        #1;
        check("dbg_reg", {24'h0, dbg_data}, {24'h0, m_regs[idx]});
    endtask

    task automatic issue(input logic [4:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic ui, input logic [7:0] imm);
        int n;
        logic [7:0] a, b;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        if (n >= 20) check("ready_timeout", {31'h0, in_ready}, 32'h1);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_use_imm = ui; in_imm = imm;
        in_valid = 1'b1;
        a = m_regs[rs1];
        b = ui ? imm : m_regs[rs2];
        step();
        in_valid = 1'b0;
        if (op == 5'h10) begin
            m_regs[rd] = imm;
            check("ldi_done", {31'h0, done}, 32'h1);
            check("ldi_wb", {24'h0, wb_data}, {24'h0, imm});
            check("ldi_flags", {27'h0, flags}, {27'h0, m_flags});
        end else begin
            check("exec_done", {31'h0, done}, 32'h0);
            check("exec_ready", {31'h0, in_ready}, 32'h0);
            check("alu_a", {24'h0, alu_a}, {24'h0, a});
            check("alu_b", {24'h0, alu_b}, {24'h0, b});
            check("alu_op", {27'h0, alu_opcode}, {27'h0, op});
            step();
            model_write(op, rd, a, b);
            check("wb_done", {31'h0, done}, 32'h1);
            check("wb_data", {24'h0, wb_data}, {24'h0, m_regs[rd]});
            check("wb_flags", {27'h0, flags}, {27'h0, m_flags});
        end
        check_reg(rd);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_flags = 5'h00;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 5'h0; in_rd = 2'd0; in_rs1 = 2'd0; in_rs2 = 2'd0;
        in_use_imm = 1'b0; in_imm = 8'h00; dbg_addr = 2'd0;
        model_reset();
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_ready", {31'h0, in_ready}, 32'h1);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_flags", {27'h0, flags}, 32'h0);
        check("rst_wb", {24'h0, wb_data}, 32'h0);
        check("rst_alu_op", {27'h0, alu_opcode}, 32'h1F);
        check("rst_alu_a", {24'h0, alu_a}, 32'h0);
        check("rst_alu_b", {24'h0, alu_b}, 32'h0);
        for (int i = 0; i < 4; i++) check_reg(2'(i));

        // Signed overflow on ADD
        issue(5'h10, 2'd1, 2'd0, 2'd0, 1'b0, 8'h7F);
        issue(5'h10, 2'd2, 2'd0, 2'd0, 1'b0, 8'h01);
        issue(5'h00, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);
        check("add_res", {24'h0, wb_data}, 32'h80);
        check("add_flags", {27'h0, flags}, 32'b01100);
        step();
        check("done_pulse", {31'h0, done}, 32'h0);

        // SUB borrow, then AND masks carry
        issue(5'h10, 2'd0, 2'd0, 2'd0, 1'b0, 8'h05);
        issue(5'h01, 2'd1, 2'd0, 2'd0, 1'b1, 8'h07);
        check("sub_res", {24'h0, wb_data}, 32'hFE);
        check("sub_flags", {27'h0, flags}, 32'b10101);
        issue(5'h02, 2'd2, 2'd1, 2'd0, 1'b1, 8'h0F);
        check("and_res", {24'h0, wb_data}, 32'h0E);
        check("and_flags", {27'h0, flags}, 32'b00100);

        // Back-to-back dependent ADDs with in_valid held
        issue(5'h10, 2'd0, 2'd0, 2'd0, 1'b0, 8'hFE);
        in_op = 5'h00; in_rd = 2'd0; in_rs1 = 2'd0; in_rs2 = 2'd0; in_use_imm = 1'b1; in_imm = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("b2b_ready", {31'h0, in_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
            step();
            if (i % 2 == 1) begin
                model_write(5'h00, 2'd0, m_regs[0], 8'h01);
                check("b2b_done", {31'h0, done}, 32'h1);
                check("b2b_wb", {24'h0, wb_data}, {24'h0, m_regs[0]});
                check("b2b_flags", {27'h0, flags}, {27'h0, m_flags});
                if (i == 3) check("b2b_wrap", {24'h0, wb_data}, 32'h00);
                if (i == 7) check("b2b_last", {24'h0, wb_data}, 32'h02);
            end else begin
                check("b2b_nodone", {31'h0, done}, 32'h0);
            end
        end
        in_valid = 1'b0;
        check_reg(2'd0);

        // Instruction presented during EXEC is only taken after return to IDLE
        in_op = 5'h00; in_rd = 2'd1; in_rs1 = 2'd0; in_use_imm = 1'b1; in_imm = 8'h10;
        in_valid = 1'b1;
        step();
        in_op = 5'h04; in_rd = 2'd2; in_rs1 = 2'd0; in_imm = 8'h33;
        check("hold_ready", {31'h0, in_ready}, 32'h0);
        step();
        model_write(5'h00, 2'd1, m_regs[0], 8'h10);
        check("hold_wb_first", {24'h0, wb_data}, {24'h0, m_regs[1]});
        check_reg(2'd2);
        step();
        in_valid = 1'b0;
        check("hold_op", {27'h0, alu_opcode}, 32'h04);
        check("hold_b", {24'h0, alu_b}, 32'h33);
        step();
        model_write(5'h04, 2'd2, m_regs[0], 8'h33);
        check("hold_wb_second", {24'h0, wb_data}, {24'h0, m_regs[2]});
        check_reg(2'd2);

        // Undefined opcode writes zero
        issue(5'h10, 2'd2, 2'd0, 2'd0, 1'b0, 8'hAA);
        issue(5'h15, 2'd2, 2'd1, 2'd0, 1'b0, 8'h00);
        check("undef_res", {24'h0, wb_data}, 32'h00);
        check("undef_flags", {27'h0, flags}, 32'b00010);

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 3) == 0) ? 5'h10 : 5'($urandom_range(0, 31));
            issue(op, 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
            if ($urandom_range(0, 2) == 0) step();
        end
        for (int i = 0; i < 4; i++) check_reg(2'(i));

        // Reset in EXEC abandons the instruction
        issue(5'h10, 2'd1, 2'd0, 2'd0, 1'b0, 8'h40);
        in_op = 5'h00; in_rd = 2'd3; in_rs1 = 2'd1; in_use_imm = 1'b1; in_imm = 8'h40;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rstx_done", {31'h0, done}, 32'h0);
        check("rstx_flags", {27'h0, flags}, 32'h0);
        check_reg(2'd3);
        step();
        check("rstx_done2", {31'h0, done}, 32'h0);
        rst = 1'b0;
        step();
        check("rstx_done3", {31'h0, done}, 32'h0);
        check("rstx_ready", {31'h0, in_ready}, 32'h1);
        check_reg(2'd3);
        check_reg(2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
